traffic_light_timer: RTL and testbench

//  Timebase for the traffic light controller: divides clk down to 1 s ticks and

---
 rtl/traffic_light_timer.sv | 74 +++++++
 tb/tb_traffic_light_timer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/traffic_light_timer.sv
// One-second timebase for the traffic light controller: prescales clk into second ticks,
// counts whole seconds since the last restart and raises the phase-elapsed level flags.
module traffic_light_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned SHORT_SEC     = 1,
    parameter int unsigned LONG_SEC      = 5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           timer_en,
    input  logic                           rst_count,
    output logic                           one_sec_timer,
    output logic                           five_sec_timer,
    output logic [$clog2(LONG_SEC+1)-1:0]  elapsed_sec
);

    localparam int unsigned TW = $clog2(TICKS_PER_SEC);
    localparam int unsigned W  = $clog2(LONG_SEC + 1);

    localparam logic [TW-1:0] TickMax  = TW'(TICKS_PER_SEC - 1);
    localparam logic [W-1:0]  ShortVal = W'(SHORT_SEC);
    localparam logic [W-1:0]  LongVal  = W'(LONG_SEC);

    logic [TW-1:0] tick_q, tick_d;
    logic [W-1:0]  sec_q, sec_d;
    logic          one_q, one_d;
    logic          five_q, five_d;
    logic          run_q;
    logic          restart;
    logic          sec_tick;

    // The first edge after reset release acts as an implicit restart, so the latency from
    // reset matches the latency from an explicit rst_count.
    assign restart  = rst_count || !run_q;
    assign sec_tick = timer_en && (tick_q == TickMax);

    always_comb begin
        tick_d = tick_q;
        sec_d  = sec_q;
        if (restart) begin
            tick_d = '0;
            sec_d  = '0;
        end else if (timer_en) begin
            tick_d = sec_tick ? '0 : tick_q + 1'b1;
            if (sec_tick && (sec_q != LongVal)) begin
                sec_d = sec_q + 1'b1;
            end
        end
        // Flags follow the next count so they switch on the same edge as elapsed_sec.
        one_d  = (sec_d >= ShortVal);
        five_d = (sec_d >= LongVal);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
            sec_q  <= '0;
            one_q  <= 1'b0;
            five_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            sec_q  <= sec_d;
            one_q  <= one_d;
            five_q <= five_d;
            run_q  <= 1'b1;
        end
    end

    assign one_sec_timer  = one_q;
    assign five_sec_timer = five_q;
    assign elapsed_sec    = sec_q;

endmodule

// File: tb/tb_traffic_light_timer.sv
// Directed bench for traffic_light_timer with a 4-cycle second, SHORT_SEC=1, LONG_SEC=5.
module tb_traffic_light_timer;

    logic       clk;
    logic       reset_n;
    logic       timer_en;
    logic       rst_count;
    logic       one_sec_timer;
    logic       five_sec_timer;
    logic [2:0] elapsed_sec;

    int n_cmp;
    int n_err;

    traffic_light_timer #(
        .TICKS_PER_SEC(4),
        .SHORT_SEC    (1),
        .LONG_SEC     (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .timer_en      (timer_en),
        .rst_count     (rst_count),
        .one_sec_timer (one_sec_timer),
        .five_sec_timer(five_sec_timer),
        .elapsed_sec   (elapsed_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] sec, input logic one,
                           input logic five);
        chk({tag, ".sec"}, 32'(elapsed_sec), 32'(sec));
        chk({tag, ".one"}, 32'(one_sec_timer), 32'(one));
        chk({tag, ".five"}, 32'(five_sec_timer), 32'(five));
    endtask

    // Advance n rising edges, then sample on the following falling edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        timer_en  = 1'b1;
        rst_count = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all("reset", 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // 1: first edge after release is edge 0; one rises at 4, five at 20
        edges(1);
        chk_all("e0", 3'd0, 1'b0, 1'b0);
        edges(3);
        chk_all("e3", 3'd0, 1'b0, 1'b0);
        edges(1);
        chk_all("e4", 3'd1, 1'b1, 1'b0);
        edges(15);
        chk_all("e19", 3'd4, 1'b1, 1'b0);
        edges(1);
        chk_all("e20", 3'd5, 1'b1, 1'b1);

        // 2: saturation at LONG_SEC
        edges(100);
        chk_all("sat", 3'd5, 1'b1, 1'b1);

        // 3: rst_count pulse clears, one rises again 4 edges later
        rst_count = 1'b1;
        edges(1);
        rst_count = 1'b0;
        chk_all("rst", 3'd0, 1'b0, 1'b0);
        edges(3);
        chk_all("rst+3", 3'd0, 1'b0, 1'b0);
        edges(1);
        chk_all("rst+4", 3'd1, 1'b1, 1'b0);

        // rst_count held high keeps everything at 0
        rst_count = 1'b1;
        edges(6);
        chk_all("hold", 3'd0, 1'b0, 1'b0);
        rst_count = 1'b0;
        edges(4);
        chk_all("hold+4", 3'd1, 1'b1, 1'b0);

        // 4: rst_count on the sec_tick edge wins (tick_cnt=3 now after 3 edges)
        edges(3);
        chk_all("pre_tick", 3'd1, 1'b1, 1'b0);
        rst_count = 1'b1;
        edges(1);
        rst_count = 1'b0;
        chk_all("tick_rst", 3'd0, 1'b0, 1'b0);

        // 5: freeze at tick_cnt=2 for 10 cycles delays one rise by 10 edges
        edges(2);
        timer_en = 1'b0;
        edges(10);
        chk_all("frozen", 3'd0, 1'b0, 1'b0);
        timer_en = 1'b1;
        edges(1);
        chk_all("e13", 3'd0, 1'b0, 1'b0);
        edges(1);
        chk_all("e14", 3'd1, 1'b1, 1'b0);

        // Freeze while flags are high: values hold
        timer_en = 1'b0;
        edges(7);
        chk_all("frz_hi", 3'd1, 1'b1, 1'b0);
        timer_en = 1'b1;
        edges(4);
        chk_all("resume", 3'd2, 1'b1, 1'b0);

        // Async reset mid-count clears immediately
        edges(2);
        reset_n = 1'b0;
        #1;
        chk_all("async", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        edges(4);
        chk_all("rel_e3", 3'd0, 1'b0, 1'b0);
        edges(1);
        chk_all("rel_e4", 3'd1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
